// File: rtl/key_input_conditioner_pkg.sv
// Shared constants and types for the key input conditioner.
package input_pkg;

  // Board key indices (key_n bit positions)
  localparam int KEY_LEFT  = 3;
  localparam int KEY_FIRE  = 2;
  localparam int KEY_RIGHT = 1;
  localparam int NUM_KEYS  = 3;

  // Default timing at 50 MHz
  localparam int DEBOUNCE_CYCLES_50M = 250000;   // 5 ms
  localparam int DB_W_50M            = 18;
  localparam int COOLDOWN_CYCLES_50M = 2500000;  // 50 ms
  localparam int CD_W_50M            = 22;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } fire_state_t;

endpackage

// File: rtl/key_input_conditioner_if.sv
// Key inputs and game-command outputs of the conditioner.
interface key_input_conditioner_if;
  logic [3:0] key_n;
  logic [1:0] user_move;
  logic       shoot;
  logic       continue_pulse;
  logic [2:0] key_state;

  // master drives raw keys and consumes commands; slave is the conditioner
  modport master (output key_n,
                  input  user_move, shoot, continue_pulse, key_state);
  modport slave  (input  key_n,
                  output user_move, shoot, continue_pulse, key_state);
endinterface

// File: rtl/key_input_conditioner_debouncer.sv
// One key: 2-flop synchroniser, stability-count debounce, edge detect.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]      r_sync;
  logic            w_pressed;
  logic            r_level;
  logic            r_level_q;
  logic [DB_W-1:0] r_cnt;

  // Synchroniser resets to released so reset release never looks like a press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], raw_n};
  end

  assign w_pressed = ~r_sync[1];

  // Level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (w_pressed == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_level_q <= 1'b0;
    else       r_level_q <= r_level;
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_q;
  assign fall  = ~r_level & r_level_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Raw active-low keys -> debounced move vector, rate-limited shoot and
// release-triggered continue pulse.
module key_input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int DB_W            = DB_W_50M,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_50M,
  parameter int CD_W            = CD_W_50M,
  parameter int AUTOFIRE_EN     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  key_input_conditioner_if.slave   bus
);

  localparam int LI = KEY_LEFT  - 1;
  localparam int FI = KEY_FIRE  - 1;
  localparam int RI = KEY_RIGHT - 1;

  // Counter widths must hold the terminal counts; anything else is a build error
  if (DB_W < 1 || DB_W > 30 || DEBOUNCE_CYCLES < 1 ||
      (DEBOUNCE_CYCLES - 1) >= (1 << DB_W)) begin : g_bad_db
    $fatal(1, "DB_W too small for DEBOUNCE_CYCLES");
  end
  if (CD_W < 1 || CD_W > 30 || COOLDOWN_CYCLES < 1 ||
      (COOLDOWN_CYCLES - 1) >= (1 << CD_W)) begin : g_bad_cd
    $fatal(1, "CD_W too small for COOLDOWN_CYCLES");
  end

  logic [NUM_KEYS-1:0] w_level, w_rise, w_fall;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw_n (bus.key_n[k+1]),
      .level (w_level[k]),
      .rise  (w_rise[k]),
      .fall  (w_fall[k])
    );
  end

  // key_n[0] is the board reset button; only the fire key's edges matter
  logic w_unused;
  assign w_unused = ^{bus.key_n[0], w_rise[LI], w_rise[RI], w_fall[LI], w_fall[RI]};

  fire_state_t     r_state, w_state_nxt;
  logic [CD_W-1:0] r_cd, w_cd_nxt;
  logic            w_fire;
  logic            r_shoot, r_cont;
  logic [1:0]      r_move;

  // Fire FSM: fire on rise (or held level with autofire) only when READY
  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_fire      = 1'b0;
    case (r_state)
      READY: begin
        if (w_rise[FI] || (AUTOFIRE_EN != 0 && w_level[FI])) begin
          w_fire      = 1'b1;
          w_cd_nxt    = CD_W'(COOLDOWN_CYCLES - 1);
          w_state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        // rises here are dropped, including the one on the terminal cycle
        if (r_cd == '0) w_state_nxt = READY;
        else            w_cd_nxt    = r_cd - 1'b1;
      end
      default: w_state_nxt = READY;
    endcase
  end

  // Fire FSM state, cooldown counter and registered shoot pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= READY;
      r_cd    <= '0;
      r_shoot <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_shoot <= w_fire;
    end
  end

  // Registered move vector (opposing keys cancel) and continue pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_move <= 2'b00;
      r_cont <= 1'b0;
    end else begin
      r_move <= (w_level[LI] & w_level[RI]) ? 2'b00 : {w_level[LI], w_level[RI]};
      r_cont <= w_fall[FI];
    end
  end

  assign bus.user_move      = r_move;
  assign bus.shoot          = r_shoot;
  assign bus.continue_pulse = r_cont;
  assign bus.key_state      = w_level;

endmodule
